// File: rtl/job_sequencer.sv
// Batch launcher for a start/ready/done compute unit: runs the unit n_jobs times per go.
// Optional watchdog on the done wait is enabled by defining JOB_SEQ_TIMEOUT_EN.
module job_sequencer #(
  parameter int unsigned COUNT_WIDTH    = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   go,
  input  logic [COUNT_WIDTH-1:0] n_jobs,
  output logic                   busy,
  output logic                   all_done,
  output logic [COUNT_WIDTH-1:0] jobs_completed,
  input  logic                   unit_ready,
  output logic                   unit_start,
  input  logic                   unit_done,
  output logic                   timed_out
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WAIT_READY = 3'd1;
  localparam logic [2:0] S_ISSUE      = 3'd2;
  localparam logic [2:0] S_WAIT_DONE  = 3'd3;
  localparam logic [2:0] S_FINISH     = 3'd4;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("job_sequencer: TIMEOUT_CYCLES must be at least 1");
  end

  logic [2:0]             state;
  logic [2:0]             state_nx;
  logic [COUNT_WIDTH-1:0] n_q;
  logic [COUNT_WIDTH-1:0] n_nx;
  logic [COUNT_WIDTH-1:0] cnt_nx;

`ifdef JOB_SEQ_TIMEOUT_EN
  localparam int unsigned WD_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_WIDTH-1:0] wd;
  logic [WD_WIDTH-1:0] wd_nx;
  logic                timed_out_nx;
`else
  assign timed_out = 1'b0;
`endif

  // State and registered outputs; outputs are decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      n_q            <= '0;
      busy           <= 1'b0;
      unit_start     <= 1'b0;
      all_done       <= 1'b0;
      jobs_completed <= '0;
`ifdef JOB_SEQ_TIMEOUT_EN
      wd             <= '0;
      timed_out      <= 1'b0;
`endif
    end else begin
      state          <= state_nx;
      n_q            <= n_nx;
      busy           <= (state_nx != S_IDLE);
      unit_start     <= (state_nx == S_ISSUE);
      all_done       <= (state_nx == S_FINISH);
      jobs_completed <= cnt_nx;
`ifdef JOB_SEQ_TIMEOUT_EN
      wd             <= wd_nx;
      timed_out      <= timed_out_nx;
`endif
    end
  end

  // Next-state, job count and watchdog logic.
  always_comb begin
    state_nx = state;
    n_nx     = n_q;
    cnt_nx   = jobs_completed;
`ifdef JOB_SEQ_TIMEOUT_EN
    wd_nx        = wd;
    timed_out_nx = timed_out;
`endif
    case (state)
      S_IDLE: begin
        if (go) begin
          cnt_nx = '0;
`ifdef JOB_SEQ_TIMEOUT_EN
          timed_out_nx = 1'b0;
`endif
          if (n_jobs != '0) begin
            n_nx     = n_jobs;
            state_nx = S_WAIT_READY;
          end else begin
            state_nx = S_FINISH;
          end
        end
      end
      S_WAIT_READY: begin
        if (unit_ready) state_nx = S_ISSUE;
      end
      S_ISSUE: begin
        state_nx = S_WAIT_DONE;
`ifdef JOB_SEQ_TIMEOUT_EN
        wd_nx = '0;
`endif
      end
      S_WAIT_DONE: begin
        if (unit_done) begin
          cnt_nx   = jobs_completed + COUNT_WIDTH'(1);
          state_nx = (cnt_nx == n_q) ? S_FINISH : S_WAIT_READY;
        end
`ifdef JOB_SEQ_TIMEOUT_EN
        else if (wd == WD_WIDTH'(TIMEOUT_CYCLES - 1)) begin
          state_nx     = S_FINISH;
          timed_out_nx = 1'b1;
        end else begin
          wd_nx = wd + WD_WIDTH'(1);
        end
`endif
      end
      S_FINISH: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_job_sequencer.sv
// Self-checking bench for job_sequencer: randomized batches against a transaction-level model.
module tb_job_sequencer;

  localparam int unsigned CW = 8;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          go;
  logic [CW-1:0] n_jobs;
  logic          busy;
  logic          all_done;
  logic [CW-1:0] jobs_completed;
  logic          unit_ready;
  logic          unit_start;
  logic          unit_done;
  logic          timed_out;

  int checks = 0;
  int errors = 0;

  job_sequencer #(.COUNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .go(go), .n_jobs(n_jobs), .busy(busy),
    .all_done(all_done), .jobs_completed(jobs_completed),
    .unit_ready(unit_ready), .unit_start(unit_start),
    .unit_done(unit_done), .timed_out(timed_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Runs one batch. The unit answers dlat cycles after each start; ready_gap < 0 means
  // random ready, otherwise ready is held low ready_gap cycles before each job.
  task automatic run_batch(input int n, input int ready_gap, input int dlat,
                           input bit stray, input bit check_latency);
    int  starts = 0;
    int  dones  = 0;
    int  pulses = 0;
    int  due    = 0;
    int  gap;
    bit  outstanding = 1'b0;
    bit  exp_ad;
    bit  prev_ready;
    bit  ended = 1'b0;
    go = 1'b1;
    n_jobs = CW'(n);
    unit_done = 1'b0;
    gap = (ready_gap > 0) ? ready_gap : 0;
    unit_ready = (ready_gap == 0);
    prev_ready = unit_ready;
    tick();
    go = 1'b0;
    n_jobs = CW'($urandom);
    exp_ad = (n == 0);
    for (int cyc = 0; cyc < 3000 && !ended; cyc++) begin
      chk("busy", busy, 1);
      chk("all_done", all_done, exp_ad);
      chk("jobs_completed", jobs_completed, dones);
      chk("timed_out", timed_out, 0);
      if (all_done) pulses++;
      if (unit_start) begin
        chk("start_while_outstanding", outstanding, 0);
        chk("start_needs_ready", prev_ready, 1);
        starts++;
        if (check_latency && starts == 1) chk("go_to_start", cyc, 1);
        outstanding = 1'b1;
        due = dlat;
      end
      if (exp_ad) begin
        tick();
        chk("busy_fall", busy, 0);
        chk("all_done_one_cycle", all_done, 0);
        chk("final_count", jobs_completed, n);
        ended = 1'b1;
      end else begin
        unit_done = 1'b0;
        if (outstanding && !unit_start) begin
          due--;
          if (due == 0) begin
            unit_done = 1'b1;
            outstanding = 1'b0;
            dones++;
            gap = (ready_gap > 0) ? ready_gap : 0;
            if (dones == n) exp_ad = 1'b1;
          end
        end else if (!outstanding && stray) begin
          unit_done = ($urandom_range(0, 3) == 0);
        end
        if (ready_gap < 0) unit_ready = $urandom_range(0, 1) == 1;
        else if (gap > 0) begin
          unit_ready = 1'b0;
          gap--;
        end else unit_ready = 1'b1;
        if (stray) go = $urandom_range(0, 1) == 1;
        prev_ready = unit_ready;
        tick();
      end
    end
    go = 1'b0;
    unit_done = 1'b0;
    chk("batch_completed_in_budget", ended, 1);
    chk("start_count", starts, n);
    chk("all_done_count", pulses, 1);
  endtask

  initial begin
    rst = 1'b1; go = 1'b1; n_jobs = CW'(3); unit_ready = 1'b1; unit_done = 1'b0;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_unit_start", unit_start, 0);
    chk("rst_all_done", all_done, 0);
    chk("rst_jobs_completed", jobs_completed, 0);
    chk("rst_timed_out", timed_out, 0);
    rst = 1'b0; go = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    run_batch(3, 0, 2, 1'b0, 1'b1);
    tick();
    chk("idle_after_batch", busy, 0);
    chk("hold_count", jobs_completed, 3);

    run_batch(0, 0, 1, 1'b0, 1'b0);
    run_batch(2, 5, 2, 1'b1, 1'b0);
    run_batch(1, 0, 1, 1'b0, 1'b1);
    run_batch(255, 0, 1, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++)
      run_batch(int'($urandom_range(0, 7)), -1, int'($urandom_range(1, TO)), 1'b1, 1'b0);

    // Reset during WAIT_DONE of job 2 of 4, then a late completion.
    go = 1'b1; n_jobs = CW'(4); unit_ready = 1'b1; unit_done = 1'b0;
    tick();
    go = 1'b0;
    tick();
    chk("rst_case_start1", unit_start, 1);
    tick(); tick();
    unit_done = 1'b1;
    tick();
    unit_done = 1'b0;
    chk("rst_case_count1", jobs_completed, 1);
    tick();
    chk("rst_case_start2", unit_start, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_count", jobs_completed, 0);
    chk("midrst_start", unit_start, 0);
    unit_done = 1'b1;
    tick();
    unit_done = 1'b0;
    chk("late_done_count", jobs_completed, 0);
    chk("late_done_busy", busy, 0);
    chk("late_done_all_done", all_done, 0);

`ifdef JOB_SEQ_TIMEOUT_EN
    // Job 1 completes, job 2 never answers: watchdog ends the batch.
    go = 1'b1; n_jobs = CW'(2);
    tick();
    go = 1'b0;
    tick();
    chk("to_start1", unit_start, 1);
    tick();
    unit_done = 1'b1;
    tick();
    unit_done = 1'b0;
    chk("to_count1", jobs_completed, 1);
    tick();
    chk("to_start2", unit_start, 1);
    for (int i = 0; i < int'(TO); i++) begin
      tick();
      chk("to_waiting", all_done, 0);
      chk("to_not_yet", timed_out, 0);
    end
    tick();
    chk("to_all_done", all_done, 1);
    chk("to_timed_out", timed_out, 1);
    chk("to_count", jobs_completed, 1);
    tick();
    chk("to_busy_fall", busy, 0);
    chk("to_sticky", timed_out, 1);
    tick();
    chk("to_still_sticky", timed_out, 1);
    run_batch(1, 0, int'(TO), 1'b0, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
